// File: rtl/pose_replay_sequencer.sv
// rtl/pose_replay_sequencer.sv - records live servo poses and replays them with slew-limited moves and timed holds
module pose_replay_sequencer #(
    parameter int DEPTH      = 16,
    parameter int W          = 13,
    parameter int HOLD_TICKS = 50
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_tick,
    input  logic         i_record,
    input  logic         i_play,
    input  logic         i_clear,
    input  logic [W-1:0] i_live0,
    input  logic [W-1:0] i_live1,
    input  logic [W-1:0] i_live2,
    input  logic [W-1:0] i_live3,
    output logic [W-1:0] o_servo0,
    output logic [W-1:0] o_servo1,
    output logic [W-1:0] o_servo2,
    output logic [W-1:0] o_servo3,
    output logic         o_replaying,
    output logic [4:0]   o_tot_state,
    output logic [4:0]   o_cur_state,
    output logic         o_full
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         HW       = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [4:0] DEPTH5   = 5'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [W-1:0]  SERVO_RST = W'(150);

    typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    servo_q [4];
    logic [W-1:0]    servo_d [4];
    logic [W-1:0]    live    [4];
    logic [W-1:0]    tgt     [4];
    logic [W-1:0]    mem     [4][DEPTH];
    logic [4:0]      tot_q, tot_d, cur_q, cur_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            wr_en;
    logic            at_tgt;

    assign live[0] = i_live0;
    assign live[1] = i_live1;
    assign live[2] = i_live2;
    assign live[3] = i_live3;

    always_comb begin
        at_tgt = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tgt[n] = mem[n][cur_q[AW-1:0]];
            if (servo_q[n] != tgt[n]) at_tgt = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        tot_d   = tot_q;
        cur_d   = cur_q;
        hold_d  = hold_q;
        wr_en   = 1'b0;
        for (int n = 0; n < 4; n++) servo_d[n] = servo_q[n];

        case (state_q)
            ST_IDLE: begin
                for (int n = 0; n < 4; n++) servo_d[n] = live[n];
                if (i_clear) begin
                    tot_d = 5'd0;
                end else if (i_record) begin
                    if (tot_q < DEPTH5) begin
                        wr_en = 1'b1;
                        tot_d = tot_q + 5'd1;
                    end
                end else if (i_play && tot_q != 5'd0) begin
                    state_d = ST_MOVE;
                    cur_d   = 5'd0;
                end
            end
            ST_MOVE: begin
                if (i_play) begin
                    state_d = ST_IDLE;
                    cur_d   = 5'd0;
                end else if (at_tgt) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end else if (i_tick) begin
                    // one LSB per tick; equal channels stay put so nothing overshoots
                    for (int n = 0; n < 4; n++) begin
                        if (servo_q[n] < tgt[n])      servo_d[n] = servo_q[n] + W'(1);
                        else if (servo_q[n] > tgt[n]) servo_d[n] = servo_q[n] - W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (i_play) begin
                    state_d = ST_IDLE;
                    cur_d   = 5'd0;
                end else if (i_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (cur_q == tot_q - 5'd1) begin
                            state_d = ST_IDLE;
                            cur_d   = 5'd0;
                        end else begin
                            state_d = ST_MOVE;
                            cur_d   = cur_q + 5'd1;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            tot_q   <= 5'd0;
            cur_q   <= 5'd0;
            hold_q  <= '0;
            for (int n = 0; n < 4; n++) servo_q[n] <= SERVO_RST;
        end else begin
            state_q <= state_d;
            tot_q   <= tot_d;
            cur_q   <= cur_d;
            hold_q  <= hold_d;
            for (int n = 0; n < 4; n++) servo_q[n] <= servo_d[n];
        end
    end

    // slot storage needs no reset: a cleared count makes old entries unreachable
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) mem[n][tot_q[AW-1:0]] <= live[n];
        end
    end

    assign o_servo0    = servo_q[0];
    assign o_servo1    = servo_q[1];
    assign o_servo2    = servo_q[2];
    assign o_servo3    = servo_q[3];
    assign o_replaying = (state_q != ST_IDLE);
    assign o_tot_state = tot_q;
    assign o_cur_state = cur_q;
    assign o_full      = (tot_q == DEPTH5);

endmodule
